// File: rtl/hash_result_fifo_if.sv
// Interface for hash_result_fifo: input stream, output stream, level and statistics.
// Handshakes: a word moves on a rising edge when valid and ready are both 1; valid never waits on ready.
interface hash_result_fifo_if #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]          data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [31:0]          data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 err_o;
  logic [LW-1:0]        level_o;
  logic                 clear_stats_i;
  logic [CNT_WIDTH-1:0] ok_cnt_o;
  logic [CNT_WIDTH-1:0] exists_cnt_o;
  logic [CNT_WIDTH-1:0] notfound_cnt_o;
  logic [CNT_WIDTH-1:0] full_cnt_o;
  logic [CNT_WIDTH-1:0] nodel_cnt_o;

  modport slave (
    input  data_i, valid_i, ready_i, clear_stats_i,
    output ready_o, data_o, valid_o, err_o, level_o,
           ok_cnt_o, exists_cnt_o, notfound_cnt_o, full_cnt_o, nodel_cnt_o
  );

  modport master (
    output data_i, valid_i, ready_i, clear_stats_i,
    input  ready_o, data_o, valid_o, err_o, level_o,
           ok_cnt_o, exists_cnt_o, notfound_cnt_o, full_cnt_o, nodel_cnt_o
  );
endinterface

// File: rtl/hash_result_fifo.sv
// First-word-fall-through FIFO for hash-table response words, with error flagging.
// Define RESULT_FIFO_STATS_EN to build the saturating per-outcome statistics counters.
module hash_result_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  hash_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [31:0]  mem [DEPTH];
  logic [31:0]  head;

  // Pointer MSB tells a full FIFO (MSBs differ) from an empty one (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.valid_i && !full;
  assign pop   = bus.ready_i && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.data_i;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Flags, unchecked middle bits and the read-data field all pass through untouched.
  assign bus.data_o  = empty ? 32'h0 : {head[31:DATA_WIDTH], head[DATA_WIDTH-1:0]};
  assign bus.valid_o = !empty;
  assign bus.ready_o = !full;
  assign bus.err_o   = !empty && (|head[31:28]);
  assign bus.level_o = wr_ptr - rd_ptr;

`ifdef RESULT_FIFO_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] ok_cnt;
  logic [CNT_WIDTH-1:0] exists_cnt;
  logic [CNT_WIDTH-1:0] notfound_cnt;
  logic [CNT_WIDTH-1:0] full_cnt;
  logic [CNT_WIDTH-1:0] nodel_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic hit);
    return (hit && !(&v)) ? v + CNT_ONE : v;
  endfunction

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_cnt       <= '0;
      exists_cnt   <= '0;
      notfound_cnt <= '0;
      full_cnt     <= '0;
      nodel_cnt    <= '0;
    end else if (bus.clear_stats_i) begin
      ok_cnt       <= '0;
      exists_cnt   <= '0;
      notfound_cnt <= '0;
      full_cnt     <= '0;
      nodel_cnt    <= '0;
    end else if (push) begin
      ok_cnt       <= sat_inc(ok_cnt,       ~|bus.data_i[31:28]);
      exists_cnt   <= sat_inc(exists_cnt,   bus.data_i[31]);
      notfound_cnt <= sat_inc(notfound_cnt, bus.data_i[30]);
      full_cnt     <= sat_inc(full_cnt,     bus.data_i[29]);
      nodel_cnt    <= sat_inc(nodel_cnt,    bus.data_i[28]);
    end
  end

  assign bus.ok_cnt_o       = ok_cnt;
  assign bus.exists_cnt_o   = exists_cnt;
  assign bus.notfound_cnt_o = notfound_cnt;
  assign bus.full_cnt_o     = full_cnt;
  assign bus.nodel_cnt_o    = nodel_cnt;
`else
  wire unused_clear_stats = bus.clear_stats_i;

  assign bus.ok_cnt_o       = '0;
  assign bus.exists_cnt_o   = '0;
  assign bus.notfound_cnt_o = '0;
  assign bus.full_cnt_o     = '0;
  assign bus.nodel_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_hash_result_fifo.sv
// Directed bench for hash_result_fifo: scoreboard queue of pushed words, popped and compared on output.
module tb_hash_result_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef RESULT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;
  hash_result_fifo_if #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  hash_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(15), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int m_ok, m_exists, m_notfound, m_full, m_nodel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
    return STATS ? 32'(v) : 32'h0;
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_ok"},       32'(bus.ok_cnt_o),       exp_cnt(m_ok));
    check({tag, "_exists"},   32'(bus.exists_cnt_o),   exp_cnt(m_exists));
    check({tag, "_notfound"}, 32'(bus.notfound_cnt_o), exp_cnt(m_notfound));
    check({tag, "_full"},     32'(bus.full_cnt_o),     exp_cnt(m_full));
    check({tag, "_nodel"},    32'(bus.nodel_cnt_o),    exp_cnt(m_nodel));
  endtask

  // Monitor at the falling edge: the handshake seen here is what the next rising edge commits.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ok = 0; m_exists = 0; m_notfound = 0; m_full = 0; m_nodel = 0;
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) check("pop_unexpected", bus.data_o, 32'hDEAD_BEEF);
        else check("pop_data", bus.data_o, exp_q.pop_front());
      end
      if (bus.clear_stats_i) begin
        m_ok = 0; m_exists = 0; m_notfound = 0; m_full = 0; m_nodel = 0;
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(bus.data_i);
        if (!bus.clear_stats_i) begin
          if (bus.data_i[31:28] == 4'h0) m_ok = sat(m_ok);
          if (bus.data_i[31]) m_exists   = sat(m_exists);
          if (bus.data_i[30]) m_notfound = sat(m_notfound);
          if (bus.data_i[29]) m_full     = sat(m_full);
          if (bus.data_i[28]) m_nodel    = sat(m_nodel);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 40 && bus.valid_o; i++) tick();
    check({tag, "_drained"}, 32'(bus.valid_o), 32'h0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    bus.ready_i = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.data_i        = '0;
    bus.valid_i       = 1'b0;
    bus.ready_i       = 1'b0;
    bus.clear_stats_i = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset / idle values
    check("rst_ready", 32'(bus.ready_o), 32'h1);
    check("rst_valid", 32'(bus.valid_o), 32'h0);
    check("rst_data",  bus.data_o,       32'h0);
    check("rst_err",   32'(bus.err_o),   32'h0);
    check("rst_level", 32'(bus.level_o), 32'h0);
    check_stats("rst");

    // Single word, one-cycle latency
    bus.data_i  = 32'h0000_1234;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("one_valid", 32'(bus.valid_o), 32'h1);
    check("one_data",  bus.data_o,       32'h0000_1234);
    check("one_err",   32'(bus.err_o),   32'h0);
    check("one_level", 32'(bus.level_o), 32'h1);
    check("one_ok_const", 32'(bus.ok_cnt_o), STATS ? 32'h1 : 32'h0);
    drain("one");

    // Fill to full, hold a 9th word, then drain
    for (int i = 1; i <= DEPTH; i++) begin
      bus.data_i  = 32'(i);
      bus.valid_i = 1'b1;
      tick();
    end
    check("full_ready", 32'(bus.ready_o), 32'h0);
    check("full_level", 32'(bus.level_o), 32'h8);
    bus.data_i = 32'h9;
    tick();
    tick();
    check("full_hold_level", 32'(bus.level_o), 32'h8);
    check("full_hold_ready", 32'(bus.ready_o), 32'h0);
    bus.ready_i = 1'b1;
    tick();
    check("first_pop_ready", 32'(bus.ready_o), 32'h1);
    check("first_pop_level", 32'(bus.level_o), 32'h7);
    tick();
    bus.valid_i = 1'b0;
    check("ninth_in_level", 32'(bus.level_o), 32'h7);
    drain("full");

    // Error flags at the head
    bus.data_i  = 32'hC000_0005;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("err_flag", 32'(bus.err_o), 32'h1);
    check("err_data", bus.data_o,     32'hC000_0005);
    check("err_exists_const",   32'(bus.exists_cnt_o),   STATS ? 32'h1 : 32'h0);
    check("err_notfound_const", 32'(bus.notfound_cnt_o), STATS ? 32'h1 : 32'h0);
    check_stats("err");
    drain("err");

    // Steady push+pop at level 3
    for (int i = 0; i < 3; i++) begin
      bus.data_i  = 32'h100 + 32'(i);
      bus.valid_i = 1'b1;
      tick();
    end
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data_i = $urandom();
      tick();
      check("steady_level", 32'(bus.level_o), 32'h3);
    end
    check_stats("steady");
    drain("steady");

    // Drive ok counter into saturation
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data_i  = 32'($urandom_range(0, 32'h0FFF_FFFF));
      bus.valid_i = 1'b1;
      tick();
    end
    bus.valid_i = 1'b0;
    check("sat_ok_const", 32'(bus.ok_cnt_o), STATS ? 32'(CMAX) : 32'h0);
    check_stats("sat");
    drain("sat");

    // Clear with a simultaneous push
    bus.data_i        = 32'hF000_0001;
    bus.valid_i       = 1'b1;
    bus.clear_stats_i = 1'b1;
    tick();
    bus.valid_i       = 1'b0;
    bus.clear_stats_i = 1'b0;
    check("clr_ok_const", 32'(bus.ok_cnt_o), 32'h0);
    check_stats("clr");
    drain("clr");

    // Asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) begin
      bus.data_i  = 32'h200 + 32'(i);
      bus.valid_i = 1'b1;
      tick();
    end
    bus.valid_i = 1'b0;
    check("pre_rst_level", 32'(bus.level_o), 32'h5);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready_o), 32'h1);
    check("arst_valid", 32'(bus.valid_o), 32'h0);
    check("arst_data",  bus.data_o,       32'h0);
    check("arst_err",   32'(bus.err_o),   32'h0);
    check("arst_level", 32'(bus.level_o), 32'h0);
    tick();
    reset = 1'b0;
    check_stats("arst");
    bus.data_i  = 32'h0000_ABCD;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("post_rst_data",  bus.data_o,       32'h0000_ABCD);
    check("post_rst_level", 32'(bus.level_o), 32'h1);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
